// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and its matching receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous byte buffer for the transmitter: wrap-bit pointers, registered level.
module serial_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // Full and empty come only from registered pointers, so a pop in the
  // same cycle never opens room for a push.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level = r_level;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Byte-to-serial transmitter: FIFO-buffered bytes sent as start/data/stop frames.
//
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit on tdo
//   DATA  | data bits on tdo, LSB first
//   STOP  | stop bit periods on tdo
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              baud_en,
  input  logic [WIDTH-1:0]                  tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tdo,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SCW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE   = 1;
  localparam logic [SCW-1:0] STOP_ONE  = 1;

  serial_state_e    r_state;
  serial_state_e    w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shift_sr;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_nxt;
  logic [SCW-1:0]   r_stop_cnt;
  logic [SCW-1:0]   w_stop_nxt;
  logic             r_tdo;
  logic             w_tdo_nxt;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_fifo_data;
  logic [LW-1:0]    w_level;

  serial_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign tx_ready   = !w_full;
  assign fifo_level = w_level;
  assign tdo        = r_tdo;
  assign busy       = (r_state != IDLE) || (w_level != '0);
  assign w_shift_sr = r_shift >> 1;

  // Frame sequencing; bit and stop counters count down to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_stop_nxt  = r_stop_cnt;
    w_tdo_nxt   = r_tdo;
    w_pop       = 1'b0;
    if (baud_en) begin
      case (r_state)
        IDLE: begin
          w_tdo_nxt = LINE_IDLE;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_tdo_nxt   = START_BIT;
            w_state_nxt = START;
          end
        end
        START: begin
          w_tdo_nxt   = r_shift[0];
          w_bit_nxt   = BIT_LAST;
          w_state_nxt = DATA;
        end
        DATA: begin
          if (r_bit_cnt != '0) begin
            w_shift_nxt = w_shift_sr;
            w_tdo_nxt   = w_shift_sr[0];
            w_bit_nxt   = r_bit_cnt - BIT_ONE;
          end else begin
            w_tdo_nxt   = STOP_BIT;
            w_stop_nxt  = STOP_LAST;
            w_state_nxt = STOP;
          end
        end
        STOP: begin
          if (r_stop_cnt != '0) begin
            w_stop_nxt = r_stop_cnt - STOP_ONE;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_tdo_nxt   = START_BIT;
            w_state_nxt = START;
          end else begin
            w_tdo_nxt   = LINE_IDLE;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_tdo_nxt   = LINE_IDLE;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, shifter, counters and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_tdo      <= LINE_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_tdo      <= w_tdo_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: frame shape, back-to-back, full FIFO, slow baud, reset.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tdo;
  logic       busy;
  logic [2:0] fifo_level;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] fb [4];

  serial_tx #(
    .WIDTH      (8),
    .STOP_BITS  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_en    (baud_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tdo        (tdo),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Bit idx of an 11-bit frame: start, 8 data LSB first, 2 stops.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Starts from IDLE with nbytes buffered; baud_en pulses once every period clks.
  task automatic run_frames(input logic [7:0] bytes [4], input int nbytes, input int period);
    int total;
    int bi;
    total = nbytes * 11 * period;
    for (int c = 0; c <= total; c++) begin
      baud_en = (c % period == 0);
      @(negedge clk);
      if (c == 0) tx_valid = 1'b0;
      if (c < total) begin
        bi = c / period;
        check("frame_tdo", 32'(tdo), 32'(frame_bit(bytes[bi / 11], bi % 11)));
        if (c % (11 * period) == 0)
          check("pop_level", 32'(fifo_level), 32'(nbytes - 1 - c / (11 * period)));
        if (c == total - 1) check("busy_last_stop", 32'(busy), 32'd1);
      end else begin
        check("busy_after_frames", 32'(busy), 32'd0);
        check("tdo_idle_after", 32'(tdo), 32'd1);
      end
    end
    baud_en = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n    = 1'b0;
    baud_en  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tdo", 32'(tdo), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(tx_ready), 32'd1);
    check("rel_tdo", 32'(tdo), 32'd1);

    // single byte 0x01
    push(8'h01);
    check("t1_level", 32'(fifo_level), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_hold_tdo", 32'(tdo), 32'd1);
    fb = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_frames(fb, 1, 1);

    // three bytes back-to-back
    push(8'h10);
    push(8'h22);
    push(8'h30);
    check("t2_level", 32'(fifo_level), 32'd3);
    fb = '{8'h10, 8'h22, 8'h30, 8'h00};
    run_frames(fb, 3, 1);

    // fill to full, overflow refused, full+pop refuses push
    push(8'hA1);
    check("t3_lvl1", 32'(fifo_level), 32'd1);
    push(8'hA2);
    check("t3_lvl2", 32'(fifo_level), 32'd2);
    push(8'hA3);
    check("t3_lvl3", 32'(fifo_level), 32'd3);
    check("t3_ready3", 32'(tx_ready), 32'd1);
    push(8'hA4);
    check("t3_lvl4", 32'(fifo_level), 32'd4);
    check("t3_ready4", 32'(tx_ready), 32'd0);
    push(8'hA5);
    check("t3_lvl5", 32'(fifo_level), 32'd4);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    fb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_frames(fb, 4, 1);

    // slow baud: one strobe in four clocks, 44-clock frame
    push(8'h43);
    fb = '{8'h43, 8'h00, 8'h00, 8'h00};
    run_frames(fb, 1, 4);

    // reset mid-DATA
    baud_en = 1'b1;
    push(8'h64);
    push(8'h11);
    repeat (4) @(negedge clk);
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tdo", 32'(tdo), 32'd1);
    check("t5_rst_level", 32'(fifo_level), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tdo !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t5_no_residual", 32'(bad), 32'd0);
    baud_en = 1'b0;
    push(8'h70);
    fb = '{8'h70, 8'h00, 8'h00, 8'h00};
    run_frames(fb, 1, 1);

    // random bytes at baud one in three
    fb[0] = 8'($urandom_range(0, 255));
    fb[1] = 8'($urandom_range(0, 255));
    fb[2] = 8'h00;
    fb[3] = 8'h00;
    push(fb[0]);
    push(fb[1]);
    run_frames(fb, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
